// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture path.
// Holds the writer FSM state type, default frame geometry and pixel format conversion.
package cam_pkg;

   typedef enum logic {
      SYNC    = 1'b0,
      CAPTURE = 1'b1
   } state_e;

   localparam int unsigned CAM_H_PIXELS = 320;
   localparam int unsigned CAM_V_LINES  = 240;

   // Keep the top four bits of each channel; green drops its two LSBs, red/blue drop one.
   function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] p);
      return {p[15:12], p[10:7], p[4:1]};
   endfunction

endpackage

// File: rtl/camera_frame_writer.sv
// Converts an RGB565 pixel stream into RGB444 BRAM writes for a ping-pong frame buffer.
// Tracks x/y position, optionally decimates, and validates each frame before flipping banks.
module camera_frame_writer
   import cam_pkg::*;
#(
   parameter int unsigned H_PIXELS  = CAM_H_PIXELS,
   parameter int unsigned V_LINES   = CAM_V_LINES,
   parameter int unsigned DEC_SHIFT = 0,
   parameter int unsigned ADDR_W    = 17
) (
   input  logic              cam_clk_in,
   input  logic              rst_in,
   input  logic [15:0]       pixel_in,
   input  logic              pixel_valid_in,
   input  logic              frame_done_in,
   output logic              wr_en_out,
   output logic [ADDR_W:0]   wr_addr_out,
   output logic [11:0]       wr_data_out,
   output logic              wr_bank_out,
   output logic [7:0]        frame_count_out,
   output logic              frame_error_out
);

   localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int unsigned YW = $clog2(V_LINES + 1);

   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_END  = YW'(V_LINES);
   localparam logic [XW-1:0] X_MASK = XW'((1 << DEC_SHIFT) - 1);
   localparam logic [YW-1:0] Y_MASK = YW'((1 << DEC_SHIFT) - 1);

   state_e              state_q, state_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ovf_q, ovf_d;
   logic                fd_q, fd_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
   logic [11:0]         wr_data_q, wr_data_d;
   logic                bank_q, bank_d;
   logic [7:0]          count_q, count_d;
   logic                err_q, err_d;

   // Position after the current pixel, before any frame_done in the same cycle is applied.
   logic [XW-1:0]       px_x;
   logic [YW-1:0]       px_y;
   logic [ADDR_W-1:0]   px_addr;
   logic                px_ovf;
   logic                fd_rise;
   logic                eligible;
   logic                good_frame;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      addr_d     = addr_q;
      ovf_d      = ovf_q;
      fd_d       = frame_done_in;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      bank_d     = bank_q;
      count_d    = count_q;
      err_d      = 1'b0;
      px_x       = x_q;
      px_y       = y_q;
      px_addr    = addr_q;
      px_ovf     = ovf_q;
      good_frame = 1'b0;

      fd_rise  = frame_done_in & ~fd_q;
      eligible = (y_q != Y_END) && ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

      unique case (state_q)
         SYNC: begin
            if (fd_rise) begin
               state_d = CAPTURE;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               ovf_d   = 1'b0;
            end
         end

         CAPTURE: begin
            if (pixel_valid_in) begin
               if (y_q == Y_END) begin
                  px_ovf = 1'b1;
               end else if (eligible) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {bank_q, addr_q};
                  wr_data_d = rgb565_to_rgb444(pixel_in);
                  px_addr   = addr_q + ADDR_W'(1);
               end

               if (x_q == X_LAST) begin
                  px_x = '0;
                  if (y_q != Y_END) begin
                     px_y = y_q + YW'(1);
                  end
               end else begin
                  px_x = x_q + XW'(1);
               end
            end

            if (fd_rise) begin
               good_frame = (px_y == Y_END) && (px_x == '0) && !px_ovf;
               if (good_frame) begin
                  bank_d  = ~bank_q;
                  count_d = count_q + 8'd1;
               end else begin
                  err_d = 1'b1;
               end
               x_d    = '0;
               y_d    = '0;
               addr_d = '0;
               ovf_d  = 1'b0;
            end else begin
               x_d    = px_x;
               y_d    = px_y;
               addr_d = px_addr;
               ovf_d  = px_ovf;
            end
         end

         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge cam_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= SYNC;
         x_q       <= '0;
         y_q       <= '0;
         addr_q    <= '0;
         ovf_q     <= 1'b0;
         fd_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         bank_q    <= 1'b0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         addr_q    <= addr_d;
         ovf_q     <= ovf_d;
         fd_q      <= fd_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         bank_q    <= bank_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   assign wr_en_out       = wr_en_q;
   assign wr_addr_out     = wr_addr_q;
   assign wr_data_out     = wr_data_q;
   assign wr_bank_out     = bank_q;
   assign frame_count_out = count_q;
   assign frame_error_out = err_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer: a 4x3 full-rate instance and a 4x4 instance
// decimated by two, driven from a shared pixel stream.
module tb_camera_frame_writer;

   logic        clk;
   logic        rst;
   logic [15:0] pixel;
   logic        valid;
   logic        fd;

   logic        wr_en0, bank0, err0;
   logic [4:0]  wr_addr0;
   logic [11:0] wr_data0;
   logic [7:0]  cnt0;

   logic        wr_en1, bank1, err1;
   logic [3:0]  wr_addr1;
   logic [11:0] wr_data1;
   logic [7:0]  cnt1;

   int errors = 0;
   int checks = 0;

   logic [4:0]  a0 [64];
   logic [11:0] d0 [64];
   int          n0 = 0;
   int          e0 = 0;
   logic [3:0]  a1 [64];
   logic [11:0] d1 [64];
   int          n1 = 0;
   int          e1 = 0;

   camera_frame_writer #(
      .H_PIXELS (4),
      .V_LINES  (3),
      .DEC_SHIFT(0),
      .ADDR_W   (4)
   ) dut0 (
      .cam_clk_in     (clk),
      .rst_in         (rst),
      .pixel_in       (pixel),
      .pixel_valid_in (valid),
      .frame_done_in  (fd),
      .wr_en_out      (wr_en0),
      .wr_addr_out    (wr_addr0),
      .wr_data_out    (wr_data0),
      .wr_bank_out    (bank0),
      .frame_count_out(cnt0),
      .frame_error_out(err0)
   );

   camera_frame_writer #(
      .H_PIXELS (4),
      .V_LINES  (4),
      .DEC_SHIFT(1),
      .ADDR_W   (3)
   ) dut1 (
      .cam_clk_in     (clk),
      .rst_in         (rst),
      .pixel_in       (pixel),
      .pixel_valid_in (valid),
      .frame_done_in  (fd),
      .wr_en_out      (wr_en1),
      .wr_addr_out    (wr_addr1),
      .wr_data_out    (wr_data1),
      .wr_bank_out    (bank1),
      .frame_count_out(cnt1),
      .frame_error_out(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write/error monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en0) begin
         if (n0 < 64) begin
            a0[n0] = wr_addr0;
            d0[n0] = wr_data0;
         end
         n0++;
      end
      if (err0) e0++;
      if (wr_en1) begin
         if (n1 < 64) begin
            a1[n1] = wr_addr1;
            d1[n1] = wr_data1;
         end
         n1++;
      end
      if (err1) e1++;
   end

   function automatic logic [15:0] pat(input int i);
      case (i % 3)
         0:       return 16'hF800;
         1:       return 16'h07E0;
         default: return 16'h001F;
      endcase
   endfunction

   function automatic logic [11:0] exp_data(input int i);
      case (i % 3)
         0:       return 12'hF00;
         1:       return 12'h0F0;
         default: return 12'h00F;
      endcase
   endfunction

   task automatic cycle(input logic v, input logic [15:0] p, input logic f);
      valid = v;
      pixel = p;
      fd    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      n0 = 0;
      e0 = 0;
      n1 = 0;
      e1 = 0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      valid = 1'b0;
      pixel = '0;
      fd    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wr_en0, wr_addr0, wr_data0, bank0, cnt0, err0} !== '0) begin
         $display("FAIL reset_dut0 got=%h want=0", {wr_en0, wr_addr0, wr_data0, bank0, cnt0, err0});
         errors++;
      end
      checks++;
      if ({wr_en1, wr_addr1, wr_data1, bank1, cnt1, err1} !== '0) begin
         $display("FAIL reset_dut1 got=%h want=0", {wr_en1, wr_addr1, wr_data1, bank1, cnt1, err1});
         errors++;
      end
      checks++;
      if (dut0.state_q !== cam_pkg::SYNC) begin
         $display("FAIL reset_state got=%0d want=%0d", dut0.state_q, cam_pkg::SYNC);
         errors++;
      end
      rst = 1'b0;
      cycle(1'b0, 16'h0, 1'b0);
   endtask

   task automatic test_sync();
      clear_mon();
      for (int i = 0; i < 5; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 0) begin
         $display("FAIL sync_writes got=%0d want=0", n0);
         errors++;
      end
      checks++;
      if (dut0.state_q !== cam_pkg::CAPTURE) begin
         $display("FAIL sync_state got=%0d want=%0d", dut0.state_q, cam_pkg::CAPTURE);
         errors++;
      end
      checks++;
      if (cnt0 !== 8'd0 || bank0 !== 1'b0 || e0 !== 0) begin
         $display("FAIL sync_flags got cnt=%0d bank=%0d err=%0d want 0 0 0", cnt0, bank0, e0);
         errors++;
      end
   endtask

   task automatic test_short_frame();
      clear_mon();
      for (int i = 0; i < 10; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (e0 !== 1) begin
         $display("FAIL short_err_pulses got=%0d want=1", e0);
         errors++;
      end
      checks++;
      if (bank0 !== 1'b0 || cnt0 !== 8'd0) begin
         $display("FAIL short_bank_cnt got bank=%0d cnt=%0d want 0 0", bank0, cnt0);
         errors++;
      end
   endtask

   task automatic test_good_frame();
      clear_mon();
      for (int i = 0; i < 12; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 12) begin
         $display("FAIL good_nwrites got=%0d want=12", n0);
         errors++;
      end
      for (int i = 0; i < 12 && i < n0; i++) begin
         checks++;
         if (a0[i] !== 5'(i) || d0[i] !== exp_data(i)) begin
            $display("FAIL good_write%0d got addr=%h data=%h want addr=%h data=%h",
                     i, a0[i], d0[i], 5'(i), exp_data(i));
            errors++;
         end
      end
      checks++;
      if (bank0 !== 1'b1 || cnt0 !== 8'd1 || e0 !== 0) begin
         $display("FAIL good_flags got bank=%0d cnt=%0d err=%0d want 1 1 0", bank0, cnt0, e0);
         errors++;
      end
   endtask

   task automatic test_overflow();
      clear_mon();
      for (int i = 0; i < 14; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 12) begin
         $display("FAIL ovf_nwrites got=%0d want=12", n0);
         errors++;
      end
      checks++;
      if (n0 >= 12 && a0[11] !== 5'd27) begin
         $display("FAIL ovf_last_addr got=%h want=%h", a0[11], 5'd27);
         errors++;
      end
      checks++;
      if (e0 !== 1 || bank0 !== 1'b1 || cnt0 !== 8'd1) begin
         $display("FAIL ovf_flags got err=%0d bank=%0d cnt=%0d want 1 1 1", e0, bank0, cnt0);
         errors++;
      end
   endtask

   task automatic test_coincident();
      clear_mon();
      for (int i = 0; i < 11; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b1, pat(11), 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 12) begin
         $display("FAIL coin_nwrites got=%0d want=12", n0);
         errors++;
      end
      checks++;
      if (n0 >= 12 && (a0[11] !== 5'd27 || d0[11] !== 12'h00F)) begin
         $display("FAIL coin_last got addr=%h data=%h want addr=1b data=00f", a0[11], d0[11]);
         errors++;
      end
      checks++;
      if (bank0 !== 1'b0 || cnt0 !== 8'd2 || e0 !== 0) begin
         $display("FAIL coin_flags got bank=%0d cnt=%0d err=%0d want 0 2 0", bank0, cnt0, e0);
         errors++;
      end
   endtask

   task automatic test_held_done();
      clear_mon();
      for (int i = 0; i < 12; i++) cycle(1'b1, pat(i), 1'b0);
      repeat (3) cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 12 || (n0 >= 1 && a0[0] !== 5'd0)) begin
         $display("FAIL held_writes got n=%0d addr0=%h want n=12 addr0=00", n0, a0[0]);
         errors++;
      end
      checks++;
      if (bank0 !== 1'b1 || cnt0 !== 8'd3 || e0 !== 0) begin
         $display("FAIL held_flags got bank=%0d cnt=%0d err=%0d want 1 3 0", bank0, cnt0, e0);
         errors++;
      end
   endtask

   task automatic test_decimation();
      logic [11:0] want [4];
      want[0] = 12'hF00;
      want[1] = 12'h00F;
      want[2] = 12'h00F;
      want[3] = 12'h0F0;
      // Realign the decimated instance to a fresh frame.
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      clear_mon();
      for (int i = 0; i < 16; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n1 !== 4) begin
         $display("FAIL dec_nwrites got=%0d want=4", n1);
         errors++;
      end
      for (int i = 0; i < 4 && i < n1; i++) begin
         checks++;
         if (a1[i] !== 4'(i) || d1[i] !== want[i]) begin
            $display("FAIL dec_write%0d got addr=%h data=%h want addr=%h data=%h",
                     i, a1[i], d1[i], 4'(i), want[i]);
            errors++;
         end
      end
      checks++;
      if (bank1 !== 1'b1 || cnt1 !== 8'd1 || e1 !== 0) begin
         $display("FAIL dec_flags got bank=%0d cnt=%0d err=%0d want 1 1 0", bank1, cnt1, e1);
         errors++;
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 5; i++) cycle(1'b1, pat(i), 1'b0);
      valid = 1'b0;
      checks++;
      if (wr_en0 !== 1'b1 || cnt0 !== 8'd3) begin
         $display("FAIL premid_state got wr_en=%0d cnt=%0d want 1 3", wr_en0, cnt0);
         errors++;
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({wr_en0, wr_addr0, wr_data0, bank0, cnt0, err0} !== '0) begin
         $display("FAIL midrst_outputs got=%h want=0", {wr_en0, wr_addr0, wr_data0, bank0, cnt0, err0});
         errors++;
      end
      checks++;
      if (dut0.state_q !== cam_pkg::SYNC) begin
         $display("FAIL midrst_state got=%0d want=%0d", dut0.state_q, cam_pkg::SYNC);
         errors++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_mon();
      for (int i = 0; i < 3; i++) cycle(1'b1, pat(i), 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      checks++;
      if (n0 !== 0 || n1 !== 0) begin
         $display("FAIL midrst_sync_writes got n0=%0d n1=%0d want 0 0", n0, n1);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_sync();
      test_short_frame();
      test_good_frame();
      test_overflow();
      test_coincident();
      test_held_done();
      test_decimation();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/camera_frame_writer.md
# camera_frame_writer

Downstream consumer of the camera capture stage: takes the assembled RGB565 pixel stream (pixel, valid, frame-done strobe), tracks x/y position, optionally decimates, converts to RGB444 and emits write-port signals for a ping-pong frame buffer in BRAM. It runs in the camera pixel-clock domain, so it needs no CDC. The display side reads the bank opposite `wr_bank_out`.

## Interface
- `H_PIXELS`, 320: active pixels per row.
- `V_LINES`, 240: active rows per frame.
- `DEC_SHIFT`, 0: decimation factor 2^DEC_SHIFT in both x and y (0..2).
- `ADDR_W`, 17: per-bank write address width; ≥ clog2((H_PIXELS>>DEC_SHIFT)*(V_LINES>>DEC_SHIFT)).
- `cam_clk_in`  input  1  sole clock, camera pixel clock.
- `rst_in`  input  1  asynchronous, active-high reset.
- `pixel_in`  input  16  RGB565 pixel, valid when `pixel_valid_in`=1.
- `pixel_valid_in`  input  1  one pixel per high cycle.
- `frame_done_in`  input  1  end-of-frame strobe, nominally one cycle.
- `wr_en_out`  output  1  BRAM write enable.
- `wr_addr_out`  output  ADDR_W+1  {bank, address}; MSB = `wr_bank_out`.
- `wr_data_out`  output  12  RGB444 {R[3:0],G[3:0],B[3:0]}.
- `wr_bank_out`  output  1  bank currently being written.
- `frame_count_out`  output  8  count of good frames, wraps 255→0.
- `frame_error_out`  output  1  one-cycle pulse on malformed frame.

## Operation
- All outputs reset to 0; state SYNC; x, y and address counters 0.
- SYNC: ignore pixels (reset may land mid-frame). On the first `frame_done_in` rising edge, go to CAPTURE with counters cleared. No bank toggle, count or error.
- CAPTURE, on each `pixel_valid_in`:
  - Write when y < V_LINES and x[DEC_SHIFT-1:0]==0 and y[DEC_SHIFT-1:0]==0.
  - `wr_data_out` = {p[15:12], p[10:7], p[4:1]}.
  - Write address comes from an incrementing counter (no multiplier). It starts at 0 per frame and advances after each write.
  - x increments. At x==H_PIXELS-1, x wraps to 0 and y increments.
  - y saturates at V_LINES. Pixels at y==V_LINES are overflow: no write, and a sticky `ovf` flag is set.
- CAPTURE, on `frame_done_in` rising edge:
  - Good frame = (y==V_LINES && x==0 && !ovf).
  - Good: toggle `wr_bank_out`, increment `frame_count_out`.
  - Bad (short, partial row, overflow): pulse `frame_error_out`. Bank and count are unchanged, so the next frame overwrites the same bank.
  - Both cases: clear x, y, address and `ovf`, and stay in CAPTURE.
- Simultaneous `pixel_valid_in` and `frame_done_in`: the pixel is processed first (written if eligible) and is included in the good-frame check.
- `frame_done_in` held high for N>1 cycles acts once (rising edge detect). Pixels arriving during the held cycles are processed normally.
- `rst_in` mid-frame: immediate return to reset values, including bank 0 and count 0. Re-enter SYNC.

## Timing
- Registered outputs. `wr_en_out`, `wr_addr_out` and `wr_data_out` appear 1 cycle after the `pixel_valid_in` cycle.
- `wr_en_out` is high for exactly one cycle per eligible pixel and is never high in SYNC.
- Bank toggle, count increment and `frame_error_out` appear 1 cycle after the `frame_done_in` edge. `frame_error_out` lasts one cycle.
- A write issued in the same cycle as a frame_done carries the old bank bit, because the bank toggles one cycle later.
- Back-to-back `pixel_valid_in` every cycle is supported with no stall. There is no backpressure; the BRAM write port always accepts.

## Structure
- Shared package `cam_pkg`:
  - state enum {SYNC, CAPTURE};
  - default H_PIXELS/V_LINES localparams;
  - function `rgb565_to_rgb444`.
- No sub-module. Position/address counters and the FSM live in one module.
- Counter widths: x is clog2(H_PIXELS); y is clog2(V_LINES+1).

## Test plan
- Reset then 5 pixels, then frame_done -> no writes; FSM enters CAPTURE; count 0; no error.
- H=4,V=3,DEC_SHIFT=0: sync, then 12 pixels 0xF800,0x07E0,0x001F,… then frame_done -> 12 writes at addr 0..11 with bank 0. Data are 0xF00, 0x0F0, 0x00F. Bank→1, count=1.
- Same frame with only 10 pixels -> `frame_error_out` pulses once; bank stays 0; count 0. The next good frame writes addr 0..11 in bank 0.
- 14 pixels (overflow) -> only 12 writes, then error pulse, bank unchanged.
- DEC_SHIFT=1, H=4,V=4, 16 pixels -> writes only for (x,y) ∈ {0,2}², at addr 0..3. Bank toggles.
- 12th pixel coincident with frame_done -> pixel written to addr 11 in bank 0, frame judged good. frame_done held 3 cycles -> count +1 only. `rst_in` asserted mid-frame -> all outputs 0 asynchronously.
